// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//   Multi-cycle multiply/divide engine holding the architectural HI/LO
//   registers of the MIPS datapath. MULT/MULTU use shift-add and DIV/DIVU use
//   restoring division, one bit per cycle, on operand magnitudes. A final FIX
//   cycle applies the sign correction and writes HI/LO. MTHI/MTLO write HI/LO
//   directly from 'a' while the unit is idle.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   start        issue strobe for op/a/b, sampled only while idle
//   op[2:0]      000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU,
//                101 MTHI, 110 MTLO, 111 reserved (ignored)
//   a, b         rs / rt operands
//   flush        cancels an in-flight op and drops a same-cycle start
//   busy         iterative op in progress (CALC or FIX)
//   done         one-cycle pulse after HI/LO were written by an iterative op
//   div_by_zero  valid with done; the finished DIV/DIVU had b == 0
//   hi, lo       HI / LO registers
//
// Configuration
//   MULDIV_FAST_MUL_EN : when defined, MULT/MULTU go straight from IDLE to
//   FIX and use a single-cycle WIDTHxWIDTH multiplier. Default build keeps all
//   four ops iterative and contains no hardware multiplier.
// ---------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Magnitude of a two's complement value; the most negative value maps to
  // itself, which is the correct magnitude when read as unsigned.
  function automatic logic [WIDTH-1:0] mag_w(input logic signed [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    r = x[WIDTH-1] ? $unsigned(-x) : $unsigned(x);
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] neg_if_w(input logic [WIDTH-1:0] x,
                                                 input logic             neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_if_2w(input logic [2*WIDTH-1:0] x,
                                                    input logic               neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

  // Issue decode
  logic op_mul, op_div, op_iter, op_signed;
  logic accept, issue;

  always_comb begin
    op_mul    = (op == OP_MULT) || (op == OP_MULTU);
    op_div    = (op == OP_DIV)  || (op == OP_DIVU);
    op_iter   = op_mul || op_div;
    op_signed = (op == OP_MULT) || (op == OP_DIV);
    accept    = (state == S_IDLE) && start && !flush;
    issue     = accept && op_iter;
  end

  // Operand / iteration registers. acc_hi:acc_lo is the product register for
  // multiply and the remainder:quotient register for divide. opnd holds the
  // multiplicand or divisor magnitude.
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd, a_raw;
  logic             mul_q, b_zero, neg_q, neg_r;

  // Per-iteration datapath
  logic [WIDTH:0]   add_sum, rem_shift, trial;
  logic             q_bit;
  logic [WIDTH-1:0] iter_hi, iter_lo;

  always_comb begin
    add_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    rem_shift = {acc_hi, acc_lo[WIDTH-1]};
    trial     = rem_shift - {1'b0, opnd};
    // No borrow out of the trial subtraction means the divisor fits.
    q_bit     = ~trial[WIDTH];
    if (mul_q) begin
      iter_hi = add_sum[WIDTH:1];
      iter_lo = {add_sum[0], acc_lo[WIDTH-1:1]};
    end else begin
      iter_hi = q_bit ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
      iter_lo = {acc_lo[WIDTH-2:0], q_bit};
    end
  end

  // Result / sign-correction datapath used in FIX
  logic [2*WIDTH-1:0] prod_mag, prod_res;
  logic [WIDTH-1:0]   quo_res, rem_res, res_hi, res_lo;

  always_comb begin
`ifdef MULDIV_FAST_MUL_EN
    prod_mag = (2*WIDTH)'(opnd) * (2*WIDTH)'(acc_lo);
`else
    prod_mag = {acc_hi, acc_lo};
`endif
    prod_res = neg_if_2w(prod_mag, neg_q);
    // Division by zero still runs the full schedule; the result is forced here.
    quo_res  = b_zero ? '1    : neg_if_w(acc_lo, neg_q);
    rem_res  = b_zero ? a_raw : neg_if_w(acc_hi, neg_r);
    if (mul_q) begin
      res_hi = prod_res[2*WIDTH-1:WIDTH];
      res_lo = prod_res[WIDTH-1:0];
    end else begin
      res_hi = rem_res;
      res_lo = quo_res;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (issue) begin
`ifdef MULDIV_FAST_MUL_EN
          state_nxt = op_mul ? S_FIX : S_CALC;
`else
          state_nxt = S_CALC;
`endif
        end
      end
      S_CALC: begin
        if (flush)                 state_nxt = S_IDLE;
        else if (cnt == CNT_LAST)  state_nxt = S_FIX;
      end
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output / control decode
  logic fix_commit;

  always_comb begin
    busy       = (state != S_IDLE);
    fix_commit = (state == S_FIX) && !flush;
  end

  // Iteration counter
  always_ff @(posedge clk) begin
    if (rst)                   cnt <= '0;
    else if (issue)            cnt <= '0;
    else if (state == S_CALC)  cnt <= cnt + 1'b1;
  end

  // Stage boundary: operand capture on issue, one iteration per CALC cycle
  always_ff @(posedge clk) begin
    if (issue) begin
      mul_q  <= op_mul;
      a_raw  <= a;
      b_zero <= (b == '0);
      neg_q  <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r  <= op_signed && a[WIDTH-1];
      acc_hi <= '0;
      if (op_mul) begin
        opnd   <= op_signed ? mag_w($signed(a)) : a;
        acc_lo <= op_signed ? mag_w($signed(b)) : b;
      end else begin
        opnd   <= op_signed ? mag_w($signed(b)) : b;
        acc_lo <= op_signed ? mag_w($signed(a)) : a;
      end
    end else if (state == S_CALC) begin
      acc_hi <= iter_hi;
      acc_lo <= iter_lo;
    end
  end

  // Stage boundary: architectural HI/LO write and completion pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= fix_commit;
      div_by_zero <= fix_commit && !mul_q && b_zero;
      if (fix_commit) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (accept && (op == OP_MTHI)) begin
        hi <= a;
      end else if (accept && (op == OP_MTLO)) begin
        lo <= a;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  localparam int W = 32;

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
  localparam logic [2:0] OP_RSVD  = 3'b111;

  logic         clk = 1'b0;
  logic         rst, start, flush;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  // Issue one op: start is high across exactly one rising edge (E0).
  task automatic issue(input logic [2:0] o, input logic [W-1:0] va, input logic [W-1:0] vb);
    @(negedge clk);
    start = 1'b1; op = o; a = va; b = vb;
    @(negedge clk);
    start = 1'b0; op = OP_NONE;
  endtask

  task automatic run_vec(input int i);
    int cycles;
    int exp_busy;
    exp_busy = W + 1;
`ifdef MULDIV_FAST_MUL_EN
    if (vecs[i].op == OP_MULT || vecs[i].op == OP_MULTU) exp_busy = 1;
`endif
    issue(vecs[i].op, vecs[i].a, vecs[i].b);
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
    chk($sformatf("v%0d busy_cycles", i), W'(cycles), W'(exp_busy));
    chk($sformatf("v%0d done", i), W'(done), 32'd1);
    chk($sformatf("v%0d hi", i), hi, vecs[i].hi);
    chk($sformatf("v%0d lo", i), lo, vecs[i].lo);
    chk($sformatf("v%0d div_by_zero", i), W'(div_by_zero), W'(vecs[i].dz));
    @(negedge clk);
    chk($sformatf("v%0d done_pulse_end", i), W'(done), 32'd0);
  endtask

  initial begin
    int dones;

    vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{OP_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1};
    vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5]  = '{OP_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0};
    vecs[6]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[7]  = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
    vecs[8]  = '{OP_DIVU,  32'd10,       32'd3,        32'd1,        32'd3,        1'b0};
    vecs[9]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    vecs[10] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
    vecs[11] = '{OP_DIV,   32'd0,        32'd0,        32'd0,        32'hFFFFFFFF, 1'b1};
    vecs[12] = '{OP_DIV,   32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};
    vecs[13] = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    vecs[14] = '{OP_DIVU,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0};
    vecs[15] = '{OP_MULTU, 32'd6,        32'd7,        32'd0,        32'd42,       1'b0};

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = OP_NONE; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    chk("reset busy", W'(busy), 32'd0);
    chk("reset done", W'(done), 32'd0);
    chk("reset div_by_zero", W'(div_by_zero), 32'd0);
    rst = 1'b0;

    // MTHI / MTLO: written on the start edge, never busy, no done
    @(negedge clk);
    start = 1'b1; op = OP_MTHI; a = 32'h1234;
    @(negedge clk);
    chk("mthi hi", hi, 32'h1234);
    chk("mthi busy", W'(busy), 32'd0);
    start = 1'b1; op = OP_MTLO; a = 32'h5678;
    @(negedge clk);
    start = 1'b0; op = OP_NONE;
    chk("mtlo lo", lo, 32'h5678);
    chk("mtlo hi_kept", hi, 32'h1234);
    chk("mtlo done", W'(done), 32'd0);

    // Reset in the middle of CALC
    issue(OP_MULTU, 32'd9, 32'd9);
    repeat (4) @(negedge clk);
    chk("midcalc busy_before", W'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midcalc_rst busy", W'(busy), 32'd0);
    chk("midcalc_rst hi", hi, 32'd0);
    chk("midcalc_rst lo", lo, 32'd0);
    chk("midcalc_rst done", W'(done), 32'd0);

    for (int i = 0; i < NV; i++) run_vec(i);

    // Flush mid-CALC: no done, HI/LO untouched
    @(negedge clk);
    start = 1'b1; op = OP_MTHI; a = 32'hAAAA;
    @(negedge clk);
    op = OP_MTLO; a = 32'hBBBB;
    @(negedge clk);
    start = 1'b0; op = OP_NONE;
    issue(OP_DIVU, 32'd10, 32'd3);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy", W'(busy), 32'd0);
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    chk("flush no_done", W'(dones), 32'd0);
    chk("flush hi_kept", hi, 32'hAAAA);
    chk("flush lo_kept", lo, 32'hBBBB);

    // Flush with start in IDLE drops the start; flush alone does nothing
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = OP_MULTU; a = 32'd5; b = 32'd5;
    @(negedge clk);
    start = 1'b0; op = OP_NONE;
    chk("flush_start busy", W'(busy), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_idle hi", hi, 32'hAAAA);
    chk("flush_idle lo", lo, 32'hBBBB);

    // op none / reserved with start: no effect
    @(negedge clk);
    start = 1'b1; op = OP_RSVD; a = 32'h9999;
    @(negedge clk);
    op = OP_NONE;
    @(negedge clk);
    start = 1'b0;
    chk("rsvd busy", W'(busy), 32'd0);
    chk("rsvd hi", hi, 32'hAAAA);
    chk("rsvd lo", lo, 32'hBBBB);

    // Start while busy is ignored: exactly one done, result of the first op
    issue(OP_DIVU, 32'd10, 32'd3);
    repeat (3) @(negedge clk);
    start = 1'b1; op = OP_MULTU; a = 32'd5; b = 32'd5;
    @(negedge clk);
    start = 1'b0; op = OP_NONE;
    dones = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    chk("busy_start done_count", W'(dones), 32'd1);
    chk("busy_start hi", hi, 32'd1);
    chk("busy_start lo", lo, 32'd3);
    chk("busy_start idle", W'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
